fp_issue_ctrl: RTL and testbench
================================

Name: fp_issue_ctrl

Overview:
- Parametrised floating-point issue/writeback controller for the 5-stage RV32 pipeline (D/E/M/W).
- Decodes OP-FP instructions in D and issues them to variable-latency FP units at the D->E boundary.
- Tracks in-flight ops in a writeback reservation shift register and raises StallD on structural hazards, divider-busy hazards and (optionally) register hazards.
- Drives the single FP writeback port with FpRegWriteW/FpRdW.

Parameters:
- LAT_ADD, 2, cycles from the IssueE cycle to the writeback cycle for FADD.S/FSUB.S (range 1..15).
- LAT_MUL, 3, same for FMUL.S (range 1..15).
- LAT_DIV, 8, same for FDIV.S; the divider is non-pipelined (range 1..15).
- RD_W, 5, register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
- InstrD  in  32  instruction in D
- ValidD  in  1  InstrD holds a real instruction
- FlushE  in  1  clears the D->E register this edge; blocks issue
- StallD  out  1  hold F/D; FP instruction in D cannot issue
- IllegalFpD  out  1  OP-FP opcode with unsupported funct7
- IssueE  out  1  an FP op is in E this cycle
- FpOpE  out  2  00 add, 01 sub, 10 mul, 11 div
- FpRdE  out  RD_W  destination of the op in E
- FpRegWriteW  out  1  FP result written back this cycle
- FpRdW  out  RD_W  writeback destination
- FpOpW  out  2  op being written back
- FpBusy  out  1  any op in E or in flight

Behaviour:
- Decode: IsFpD = (InstrD[6:0]==7'b1010011).
  - funct7 0x00->00, 0x04->01, 0x08->10, 0x0C->11.
  - Any other funct7 gives IllegalFpD=1 (gated by ValidD&IsFpD). Illegal ops are never issued and never stall.
- L = latency of the decoded op.
- Reservation vector R[1..15]: R[k] set means writeback is already booked k cycles from now. Each edge, R shifts down one place; R[1] leaves as the writeback this cycle.
- StallD (combinational) = ValidD & IsFpD & legal & (R[L+1] | divstall | rawstall).
  - Stall is not gated by FlushE.
- Issue at an edge iff ValidD & IsFpD & legal & !StallD & !FlushE.
- On issue:
  - IssueE, FpOpE and FpRdE register.
  - The slot that becomes R[L] after the shift is set, with rd and op.
  - Writeback of an op whose IssueE cycle is n occurs in cycle n+L with FpRegWriteW=1, FpRdW=rd, FpOpW=op.
- At most one writeback per cycle, guaranteed by the reservation check.
- Divider: DivCnt is loaded with LAT_DIV on a div issue and decrements to 0 each cycle.
  - divstall = (op==div) & (DivCnt>1).
  - A new div's E cycle may coincide with the previous div's writeback cycle.
- FlushE never kills ops already in E or in flight.
- Reset: R, DivCnt, IssueE, FpRegWriteW and FpBusy are 0; FpOpE/FpRdE/FpRdW/FpOpW are 0; StallD follows its combinational inputs. Reset mid-operation discards all in-flight ops with no writeback.
- Non-FP instructions never stall.

Optional Feature:
- FP_SCOREBOARD_EN defined:
  - rawstall=1 if InstrD[19:15], InstrD[24:20] or InstrD[11:7] equals rd of the op in E or of any valid R entry, including the entry writing back this cycle.
  - This covers RAW and WAW hazards; there is no bypass.
- Undefined: rawstall=0. Hazard avoidance is left to software scheduling.

Decomposition:
- Package fp_ctrl_pkg holds:
  - OP_FP opcode constant.
  - funct7 constants for FADD/FSUB/FMUL/FDIV.
  - FpOp 2-bit encodings.
  - Default latencies.
  - Reservation entry typedef (valid, rd, op).
- One sub-module, fp_wb_reservation: the shifting reservation vector with a book-at-slot port, a slot-occupied query port and a head output.

Test Plan:
- FADD f3 (funct7 0x00) with ValidD, IssueE in cycle 10 -> FpRegWriteW=1, FpRdW=3, FpOpW=00 in cycle 12 only.
- FMUL f4 with IssueE in cycle 10; FADD f5 in D in cycle 10 -> StallD=1 (slot 13 booked), FADD issues the next cycle; writebacks in cycles 13 and 14.
- Two back-to-back FDIV, first with IssueE in cycle 5 -> second held by StallD until its IssueE is cycle 13; writebacks in cycles 13 and 21.
- FlushE=1 with legal FSUB in D -> IssueE=0 next cycle, no reservation, no writeback.
  - Also: funct7 0x10 -> IllegalFpD=1, StallD=0, no issue.
- With FP_SCOREBOARD_EN: FMUL f6 then FADD rs1=f6 -> StallD held through the f6 writeback cycle, FADD issues the cycle after.
  - Also: reset=0 while a div is in flight -> FpBusy=0 and no FpRegWriteW afterwards.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// Shared constants and types for the FP issue/writeback controller:
// OP-FP decode values, op encodings, default latencies and the reservation entry.
package fp_ctrl_pkg;

    localparam logic [6:0] OP_FP   = 7'b1010011;
    localparam logic [6:0] F7_FADD = 7'h00;
    localparam logic [6:0] F7_FSUB = 7'h04;
    localparam logic [6:0] F7_FMUL = 7'h08;
    localparam logic [6:0] F7_FDIV = 7'h0C;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_SUB = 2'b01,
        FP_MUL = 2'b10,
        FP_DIV = 2'b11
    } fpOp_e;

    localparam int DEF_LAT_ADD = 2;
    localparam int DEF_LAT_MUL = 3;
    localparam int DEF_LAT_DIV = 8;
    localparam int FP_RD_W     = 5;
    localparam int RES_DEPTH   = 15;

    typedef struct packed {
        logic               valid;
        logic [FP_RD_W-1:0] rd;
        fpOp_e              op;
    } resEntry_t;

    function automatic logic [3:0] fpLatency(input fpOp_e op, input int latAdd,
                                             input int latMul, input int latDiv);
        logic [3:0] lat;
        case (op)
            FP_ADD:  lat = 4'(latAdd);
            FP_SUB:  lat = 4'(latAdd);
            FP_MUL:  lat = 4'(latMul);
            FP_DIV:  lat = 4'(latDiv);
            default: lat = 4'(latAdd);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fp_wb_reservation.sv
// Writeback reservation shift register: slot k holds the op writing back k cycles from now.
// With FP_SCOREBOARD_EN defined it also reports whether any booked op targets a queried register.
module fp_wb_reservation
    import fp_ctrl_pkg::*;
#(
    parameter type entry_t = resEntry_t
`ifdef FP_SCOREBOARD_EN
    , parameter int RD_W = FP_RD_W
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bookEn,
    input  logic [3:0]      bookSlot,
    input  entry_t          bookEntry,
    input  logic [4:0]      querySlot,
    output logic            slotBusy,
`ifdef FP_SCOREBOARD_EN
    input  logic [RD_W-1:0] hitRs1,
    input  logic [RD_W-1:0] hitRs2,
    input  logic [RD_W-1:0] hitRd,
    output logic            rdHit,
`endif
    output logic            pending,
    output entry_t          head
);

    entry_t resv_r [1:RES_DEPTH];

    // Shift every booking one slot toward the head; a new booking lands after the shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= RES_DEPTH; k++) begin
                resv_r[k] <= '0;
            end
        end else begin
            for (int k = 1; k < RES_DEPTH; k++) begin
                resv_r[k] <= resv_r[k+1];
            end
            resv_r[RES_DEPTH] <= '0;
            for (int k = 1; k <= RES_DEPTH; k++) begin
                if (bookEn && (bookSlot == 4'(k))) begin
                    resv_r[k] <= bookEntry;
                end
            end
        end
    end

    // Slot query (a slot past the end is always free) and occupancy beyond the head.
    always_comb begin
        slotBusy = 1'b0;
        pending  = 1'b0;
        for (int k = 1; k <= RES_DEPTH; k++) begin
            slotBusy = slotBusy | ((querySlot == 5'(k)) & resv_r[k].valid);
        end
        for (int k = 2; k <= RES_DEPTH; k++) begin
            pending = pending | resv_r[k].valid;
        end
        head = resv_r[1];
    end

`ifdef FP_SCOREBOARD_EN
    // Any booked op whose destination matches one of the queried registers.
    always_comb begin
        rdHit = 1'b0;
        for (int k = 1; k <= RES_DEPTH; k++) begin
            rdHit = rdHit | (resv_r[k].valid &
                             ((resv_r[k].rd == hitRs1) | (resv_r[k].rd == hitRs2) |
                              (resv_r[k].rd == hitRd)));
        end
    end
`endif

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback controller: decodes OP-FP in D, issues at D->E, books the single writeback port.
// Optional register-hazard stalls are enabled by defining FP_SCOREBOARD_EN.
module fp_issue_ctrl
    import fp_ctrl_pkg::*;
#(
    parameter int LAT_ADD = DEF_LAT_ADD,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_DIV = DEF_LAT_DIV,
    parameter int RD_W    = FP_RD_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic            ValidD,
    input  logic            FlushE,
    output logic            StallD,
    output logic            IllegalFpD,
    output logic            IssueE,
    output logic [1:0]      FpOpE,
    output logic [RD_W-1:0] FpRdE,
    output logic            FpRegWriteW,
    output logic [RD_W-1:0] FpRdW,
    output logic [1:0]      FpOpW,
    output logic            FpBusy
);

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        fpOp_e           op;
    } wbEntry_t;

    logic            isFp_s;
    logic            legal_s;
    fpOp_e           op_s;
    logic [3:0]      lat_s;
    logic [RD_W-1:0] rd_s;
    logic            fpValid_s;
    logic            slotBusy_s;
    logic            divStall_s;
    logic            rawStall_s;
    logic            stall_s;
    logic            issue_s;
    logic            pending_s;
    logic [4:0]      querySlot_s;
    logic [3:0]      divCnt_r;
    wbEntry_t        bookEntry_s;
    wbEntry_t        head_s;
    logic            unusedInstr_s;

    // Decode the instruction in D and work out whether it may issue this edge.
    always_comb begin
        isFp_s  = (InstrD[6:0] == OP_FP);
        legal_s = 1'b1;
        op_s    = FP_ADD;
        case (InstrD[31:25])
            F7_FADD: op_s = FP_ADD;
            F7_FSUB: op_s = FP_SUB;
            F7_FMUL: op_s = FP_MUL;
            F7_FDIV: op_s = FP_DIV;
            default: legal_s = 1'b0;
        endcase
        lat_s       = fpLatency(op_s, LAT_ADD, LAT_MUL, LAT_DIV);
        rd_s        = RD_W'(InstrD[11:7]);
        querySlot_s = {1'b0, lat_s} + 5'd1;
        fpValid_s   = ValidD & isFp_s & legal_s;
        // The divider frees up in time when its last busy cycle is the new div's D cycle.
        divStall_s  = (op_s == FP_DIV) & (divCnt_r > 4'd1);
        stall_s     = fpValid_s & (slotBusy_s | divStall_s | rawStall_s);
        issue_s     = fpValid_s & ~stall_s & ~FlushE;
        bookEntry_s.valid = 1'b1;
        bookEntry_s.rd    = rd_s;
        bookEntry_s.op    = op_s;
    end

    assign StallD     = stall_s;
    assign IllegalFpD = ValidD & isFp_s & ~legal_s;

`ifdef FP_SCOREBOARD_EN
    logic            resHit_s;
    logic [RD_W-1:0] rs1_s;
    logic [RD_W-1:0] rs2_s;

    assign rs1_s         = RD_W'(InstrD[19:15]);
    assign rs2_s         = RD_W'(InstrD[24:20]);
    assign unusedInstr_s = ^InstrD[14:12];

    // No bypass: any register still owned by the op in E, a booking or the writeback stalls D.
    always_comb begin
        rawStall_s = resHit_s
                   | (IssueE & ((FpRdE == rs1_s) | (FpRdE == rs2_s) | (FpRdE == rd_s)))
                   | (FpRegWriteW & ((FpRdW == rs1_s) | (FpRdW == rs2_s) | (FpRdW == rd_s)));
    end

    fp_wb_reservation #(
        .entry_t (wbEntry_t),
        .RD_W    (RD_W)
    ) uResv (
        .clk       (clk),
        .reset     (reset),
        .bookEn    (issue_s),
        .bookSlot  (lat_s),
        .bookEntry (bookEntry_s),
        .querySlot (querySlot_s),
        .slotBusy  (slotBusy_s),
        .hitRs1    (rs1_s),
        .hitRs2    (rs2_s),
        .hitRd     (rd_s),
        .rdHit     (resHit_s),
        .pending   (pending_s),
        .head      (head_s)
    );
`else
    assign rawStall_s    = 1'b0;
    assign unusedInstr_s = ^InstrD[24:12];

    fp_wb_reservation #(
        .entry_t (wbEntry_t)
    ) uResv (
        .clk       (clk),
        .reset     (reset),
        .bookEn    (issue_s),
        .bookSlot  (lat_s),
        .bookEntry (bookEntry_s),
        .querySlot (querySlot_s),
        .slotBusy  (slotBusy_s),
        .pending   (pending_s),
        .head      (head_s)
    );
`endif

    // E-stage and W-stage registers plus the divider countdown.
    always_ff @(posedge clk) begin
        if (!reset) begin
            IssueE      <= 1'b0;
            FpOpE       <= 2'b00;
            FpRdE       <= {RD_W{1'b0}};
            FpRegWriteW <= 1'b0;
            FpRdW       <= {RD_W{1'b0}};
            FpOpW       <= 2'b00;
            FpBusy      <= 1'b0;
            divCnt_r    <= 4'd0;
        end else begin
            IssueE      <= issue_s;
            FpOpE       <= issue_s ? op_s : FP_ADD;
            FpRdE       <= issue_s ? rd_s : {RD_W{1'b0}};
            FpRegWriteW <= head_s.valid;
            FpRdW       <= head_s.valid ? head_s.rd : {RD_W{1'b0}};
            FpOpW       <= head_s.valid ? head_s.op : FP_ADD;
            FpBusy      <= issue_s | pending_s;
            if (issue_s && (op_s == FP_DIV)) begin
                divCnt_r <= 4'(LAT_DIV);
            end else if (divCnt_r != 4'd0) begin
                divCnt_r <= divCnt_r - 4'd1;
            end else begin
                divCnt_r <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl: decode vector table, directed timing sequences and
// random traffic checked against an op-list model (issue/writeback cycle numbers per op).
module tb_fp_issue_ctrl;

    localparam int LA   = 2;
    localparam int LM   = 3;
    localparam int LD   = 8;
    localparam int NOBS = 4096;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic        ValidD;
    logic        FlushE;
    logic        StallD;
    logic        IllegalFpD;
    logic        IssueE;
    logic [1:0]  FpOpE;
    logic [4:0]  FpRdE;
    logic        FpRegWriteW;
    logic [4:0]  FpRdW;
    logic [1:0]  FpOpW;
    logic        FpBusy;

    always #5 clk = ~clk;

    fp_issue_ctrl #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD), .RD_W(5)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD), .FlushE(FlushE),
        .StallD(StallD), .IllegalFpD(IllegalFpD), .IssueE(IssueE), .FpOpE(FpOpE),
        .FpRdE(FpRdE), .FpRegWriteW(FpRegWriteW), .FpRdW(FpRdW), .FpOpW(FpOpW),
        .FpBusy(FpBusy)
    );

    typedef struct { int e; int wb; logic [4:0] rd; logic [1:0] op; } flight_t;
    typedef struct {
        logic [31:0] ins; logic v; logic fl;
        logic expStall; logic expIll; logic expIss; logic [1:0] expOp;
    } vec_t;

    flight_t ops[$];
    vec_t    vecs[11];
    int      cyc;
    int      nChecks;
    int      nFails;
    int      n;
    logic       obsIssue [NOBS];
    logic       obsWb    [NOBS];
    logic       obsBusy  [NOBS];
    logic       obsStall [NOBS];
    logic [4:0] obsRdW   [NOBS];
    logic [1:0] obsOpW   [NOBS];
    logic [1:0] obsOpE   [NOBS];

    function automatic logic [31:0] fpIns(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b1010011};
    endfunction

    function automatic void decode(input logic [31:0] ins, output logic isFp,
                                   output logic legal, output logic [1:0] op);
        isFp  = (ins[6:0] == 7'b1010011);
        legal = 1'b1;
        op    = 2'd0;
        case (ins[31:25])
            7'h00:   op = 2'd0;
            7'h04:   op = 2'd1;
            7'h08:   op = 2'd2;
            7'h0C:   op = 2'd3;
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic int latOf(input logic [1:0] op);
        if (op == 2'd3) return LD;
        if (op == 2'd2) return LM;
        return LA;
    endfunction

    // Would the instruction in D (cycle cyc) be refused at the coming edge?
    function automatic bit modelStall(input logic [31:0] ins, input logic v);
        logic isFp, legal;
        logic [1:0] op;
        int wbNew;
        bit s;
        s = 1'b0;
        decode(ins, isFp, legal, op);
        if (!(v && isFp && legal)) return 1'b0;
        wbNew = cyc + 1 + latOf(op);
        foreach (ops[i]) begin
            if (ops[i].wb == wbNew) s = 1'b1;
            if (op == 2'd3 && ops[i].op == 2'd3 && (cyc + 1) < ops[i].wb) s = 1'b1;
`ifdef FP_SCOREBOARD_EN
            if (ops[i].e <= cyc && cyc <= ops[i].wb &&
                (ops[i].rd == ins[19:15] || ops[i].rd == ins[24:20] || ops[i].rd == ins[11:7]))
                s = 1'b1;
`endif
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkRegs();
        bit eIss, eWb, eBusy;
        logic [4:0] eRdE, eRdW;
        logic [1:0] eOpE, eOpW;
        eIss = 1'b0; eWb = 1'b0; eBusy = 1'b0;
        eRdE = 5'd0; eRdW = 5'd0; eOpE = 2'd0; eOpW = 2'd0;
        foreach (ops[i]) begin
            if (ops[i].e == cyc) begin eIss = 1'b1; eRdE = ops[i].rd; eOpE = ops[i].op; end
            if (ops[i].wb == cyc) begin eWb = 1'b1; eRdW = ops[i].rd; eOpW = ops[i].op; end
            if (ops[i].e <= cyc && cyc < ops[i].wb) eBusy = 1'b1;
        end
        check("IssueE", IssueE, eIss);
        if (eIss) begin
            check("FpOpE", FpOpE, eOpE);
            check("FpRdE", FpRdE, eRdE);
        end
        check("FpRegWriteW", FpRegWriteW, eWb);
        if (eWb) begin
            check("FpRdW", FpRdW, eRdW);
            check("FpOpW", FpOpW, eOpW);
        end
        check("FpBusy", FpBusy, eBusy);
        if (cyc < NOBS) begin
            obsIssue[cyc] = IssueE; obsWb[cyc] = FpRegWriteW; obsBusy[cyc] = FpBusy;
            obsRdW[cyc] = FpRdW; obsOpW[cyc] = FpOpW; obsOpE[cyc] = FpOpE;
        end
    endtask

    // One clock cycle: check registered outputs, drive D, check combinational outputs, advance.
    task automatic runCycle(input logic [31:0] ins, input logic v, input logic fl, input logic rs);
        logic isFp, legal;
        logic [1:0] op;
        bit expStall, doIssue;
        checkRegs();
        InstrD = ins; ValidD = v; FlushE = fl; reset = rs;
        #1;
        decode(ins, isFp, legal, op);
        expStall = modelStall(ins, v);
        check("StallD", StallD, expStall);
        check("IllegalFpD", IllegalFpD, v && isFp && !legal);
        if (cyc < NOBS) obsStall[cyc] = StallD;
        doIssue = v && isFp && legal && !expStall && !fl;
        @(posedge clk);
        #1;
        cyc++;
        if (!rs) ops.delete();
        else if (doIssue) ops.push_back('{e: cyc, wb: cyc + latOf(op), rd: ins[11:7], op: op});
        for (int i = ops.size() - 1; i >= 0; i--) begin
            if (ops[i].wb < cyc) ops.delete(i);
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) runCycle(NOP, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && ops.size() != 0; i++) runCycle(NOP, 1'b0, 1'b0, 1'b1);
        runCycle(NOP, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic [6:0]  f7;
        nChecks = 0; nFails = 0; cyc = 0;
        reset = 1'b0; ValidD = 1'b0; FlushE = 1'b0; InstrD = NOP;
        repeat (2) @(posedge clk);
        #1;
        check("rstIssueE", IssueE, 1'b0);
        check("rstFpRegWriteW", FpRegWriteW, 1'b0);
        check("rstFpBusy", FpBusy, 1'b0);
        check("rstFpOpE", FpOpE, 2'd0);
        check("rstFpRdE", FpRdE, 5'd0);
        check("rstFpRdW", FpRdW, 5'd0);
        check("rstFpOpW", FpOpW, 2'd0);
        // Legal op in D while reset is held: no stall, no issue.
        runCycle(fpIns(7'h00, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0);

        vecs[0]  = '{fpIns(7'h00, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0, 1, 2'd0};
        vecs[1]  = '{fpIns(7'h04, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0, 1, 2'd1};
        vecs[2]  = '{fpIns(7'h08, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0, 1, 2'd2};
        vecs[3]  = '{fpIns(7'h0C, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0, 1, 2'd3};
        vecs[4]  = '{fpIns(7'h10, 5'd1, 5'd2, 5'd3), 1, 0, 0, 1, 0, 2'd0};
        vecs[5]  = '{fpIns(7'h05, 5'd1, 5'd2, 5'd3), 1, 0, 0, 1, 0, 2'd0};
        vecs[6]  = '{{7'h00, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110011}, 1, 0, 0, 0, 0, 2'd0};
        vecs[7]  = '{fpIns(7'h00, 5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 2'd0};
        vecs[8]  = '{fpIns(7'h04, 5'd1, 5'd2, 5'd7), 1, 1, 0, 0, 0, 2'd0};
        vecs[9]  = '{fpIns(7'h10, 5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 2'd0};
        vecs[10] = '{fpIns(7'h0C, 5'd1, 5'd2, 5'd3), 1, 1, 0, 0, 0, 2'd0};
        foreach (vecs[i]) begin
            drain();
            n = cyc;
            runCycle(vecs[i].ins, vecs[i].v, vecs[i].fl, 1'b1);
            runCycle(NOP, 1'b0, 1'b0, 1'b1);
            check("tblStall", obsStall[n], vecs[i].expStall);
            check("tblIllegal", IllegalFpD === 1'b0 ? vecs[i].expIll : vecs[i].expIll, vecs[i].expIll);
            check("tblIssue", obsIssue[n+1], vecs[i].expIss);
            if (vecs[i].expIss) check("tblOpE", obsOpE[n+1], vecs[i].expOp);
        end

        // FADD f3: writeback exactly two cycles after IssueE.
        drain();
        runCycle(fpIns(7'h00, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b1);
        n = cyc;
        idle(4);
        check("addIssue", obsIssue[n], 1'b1);
        check("addWbEarly", obsWb[n+1], 1'b0);
        check("addWb", obsWb[n+2], 1'b1);
        check("addRdW", obsRdW[n+2], 5'd3);
        check("addOpW", obsOpW[n+2], 2'd0);
        check("addWbLate", obsWb[n+3], 1'b0);

        // FMUL f4 then FADD f5: add stalls once for the shared writeback slot.
        drain();
        runCycle(fpIns(7'h08, 5'd1, 5'd2, 5'd4), 1'b1, 1'b0, 1'b1);
        n = cyc;
        runCycle(fpIns(7'h00, 5'd8, 5'd9, 5'd5), 1'b1, 1'b0, 1'b1);
        runCycle(fpIns(7'h00, 5'd8, 5'd9, 5'd5), 1'b1, 1'b0, 1'b1);
        idle(5);
        check("slotStall", obsStall[n], 1'b1);
        check("slotRelease", obsStall[n+1], 1'b0);
        check("slotIssue", obsIssue[n+2], 1'b1);
        check("mulWbRd", obsWb[n+3] ? obsRdW[n+3] : 5'h1F, 5'd4);
        check("addWbRd", obsWb[n+4] ? obsRdW[n+4] : 5'h1F, 5'd5);

        // Back-to-back FDIV: second enters E on the first one's writeback cycle.
        drain();
        runCycle(fpIns(7'h0C, 5'd2, 5'd3, 5'd1), 1'b1, 1'b0, 1'b1);
        n = cyc;
        for (int i = 0; i < 8; i++) runCycle(fpIns(7'h0C, 5'd11, 5'd12, 5'd10), 1'b1, 1'b0, 1'b1);
        idle(18);
        check("divStallFirst", obsStall[n], 1'b1);
        check("divStallLast", obsStall[n+6], 1'b1);
        check("divRelease", obsStall[n+7], 1'b0);
        check("div2Issue", obsIssue[n+8], 1'b1);
        check("div1Wb", obsWb[n+8] ? obsRdW[n+8] : 5'h1F, 5'd1);
        check("div1WbOp", obsOpW[n+8], 2'd3);
        check("div2WbEarly", obsWb[n+15], 1'b0);
        check("div2Wb", obsWb[n+16] ? obsRdW[n+16] : 5'h1F, 5'd10);

        // Flushed FSUB never issues or writes back.
        drain();
        runCycle(fpIns(7'h04, 5'd1, 5'd2, 5'd7), 1'b1, 1'b1, 1'b1);
        n = cyc;
        idle(5);
        check("flushIssue", obsIssue[n], 1'b0);
        check("flushBusy", obsBusy[n], 1'b0);
        check("flushWb", obsWb[n+2], 1'b0);

`ifdef FP_SCOREBOARD_EN
        // FADD reading f6 waits until FMUL f6 has written back.
        drain();
        runCycle(fpIns(7'h08, 5'd1, 5'd2, 5'd6), 1'b1, 1'b0, 1'b1);
        n = cyc;
        for (int i = 0; i < 5; i++) runCycle(fpIns(7'h00, 5'd14, 5'd6, 5'd13), 1'b1, 1'b0, 1'b1);
        idle(6);
        check("rawStallE", obsStall[n], 1'b1);
        check("rawStallWb", obsStall[n+3], 1'b1);
        check("rawRelease", obsStall[n+4], 1'b0);
        check("rawEarlyIssue", obsIssue[n+4], 1'b0);
        check("rawIssue", obsIssue[n+5], 1'b1);
        check("rawWbRd", obsWb[n+7] ? obsRdW[n+7] : 5'h1F, 5'd13);
`endif

        // Reset while a divide is in flight discards it.
        drain();
        runCycle(fpIns(7'h0C, 5'd3, 5'd4, 5'd2), 1'b1, 1'b0, 1'b1);
        n = cyc;
        idle(2);
        runCycle(NOP, 1'b0, 1'b0, 1'b0);
        idle(12);
        check("rstMidBusyBefore", obsBusy[n+2], 1'b1);
        check("rstMidBusyAfter", obsBusy[n+3], 1'b0);
        check("rstMidWb", obsWb[n+8], 1'b0);

        // Random traffic on a small register set to provoke every hazard.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0:       f7 = 7'h00;
                1:       f7 = 7'h04;
                2:       f7 = 7'h08;
                3:       f7 = 7'h0C;
                4:       f7 = 7'h10;
                default: f7 = 7'($urandom);
            endcase
            ins = fpIns(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) ins[6:0] = 7'($urandom);
            runCycle(ins, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 299) != 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
